top: RTL and testbench
======================

Name: top

Overview:
- Top-level of the DE-series counter demo: an 8-bit up/down counter driven by a prescaled 50 MHz clock, controlled by slide switches and pushbuttons, with the count shown on the red LEDs.
- It is the only user module under the board/simulator wrapper.
- Its ports match the board pin names.

Parameters:
TICK_DIV  5000000  CLOCK_50 cycles per count tick (10 Hz); must be >= 2; benches override to 4
CNT_W  8  counter width (LEDR[CNT_W-1:0])

Ports:
CLOCK_50  input  1  sole clock, 50 MHz, rising edge
KEY  input  4  pushbuttons, active-low (0 = pressed); KEY[0] is the async active-low reset, KEY[1]=load, KEY[2]=step, KEY[3]=clear
SW  input  10  SW[7:0] load value, SW[8] direction (1 up, 0 down), SW[9] run enable
LEDR  output  10  LEDR[7:0] count, LEDR[8] heartbeat, LEDR[9] terminal-count flag

Behaviour:
- Clocking: one clock, CLOCK_50. Reset is asynchronous and active-low on KEY[0]; no other async logic.
- Reset (KEY[0]=0), immediate and held:
  - count=0, prescaler=0, heartbeat=0.
  - KEY[3:1] synchronizer/edge flops = 1 (released).
  - LEDR[7:0]=0, LEDR[8]=0; LEDR[9] is 1 only if SW[8]=0 (count 0 while counting down).
- Prescaler:
  - counts 0..TICK_DIV-1 while SW[9]=1; tick is asserted for one cycle when the value is TICK_DIV-1, then it wraps to 0.
  - SW[9]=0: prescaler holds its value and no ticks occur.
  - It is cleared to 0 by load or clear.
- Key conditioning for KEY[3:1]:
  - each bit passes through 3 flops (s1<=KEY, s2<=s1, s3<=s2).
  - press = s3 & ~s2, a one-cycle pulse per falling edge.
  - A KEY low before rising edge n updates the count at edge n+2. Holding a key gives exactly one press; release does nothing.
- Count update per cycle, priority highest first:
  1. clear press: count<=0, prescaler<=0
  2. load press: count<=SW[7:0], prescaler<=0
  3. step press: count<=count±1 per SW[8]; ignores SW[9]; prescaler unaffected
  4. tick: count<=count±1 per SW[8]
  5. otherwise hold
- If step and tick coincide, only one increment is applied.
- Arithmetic is modulo 2^CNT_W:
  - up from 0xFF wraps to 0x00.
  - down from 0x00 wraps to 0xFF.
  - SW[8] is sampled in the cycle of the update; changing it mid-run takes effect on the next update.
- LEDR[7:0] = count register, direct.
- LEDR[8]: heartbeat register, toggles on every tick. Step, load and clear do not toggle it.
- LEDR[9]: combinational = (SW[8] & count==0xFF) | (~SW[8] & count==0x00).
- SW[9:0] are used without synchronization (quasi-static); SW[7:0] is sampled only at the load edge.
- Reset asserted mid-operation aborts everything immediately. After release, counting resumes from 0 with a full TICK_DIV period before the first tick.

Test Plan:
1. TICK_DIV=4, KEY=4'b1110 for 3 cycles, then KEY=4'b1111, SW=10'b11_0000_0000 -> LEDR[7:0] increments 0,1,2,... every 4 clocks; first increment at the 4th rising edge after reset release; LEDR[8] toggles with each increment.
2. Count up to 0xFF -> LEDR[9]=1; next tick -> LEDR[7:0]=0x00, LEDR[9]=0. Then SW[8]=0 -> LEDR[9]=1 and the next tick gives 0xFF.
3. SW[9]=0, SW[7:0]=0xA5, KEY[1] low for 10 cycles -> LEDR[7:0]=0xA5 exactly 3 edges after the press; no further change while held or on release.
4. SW[9]=0, count=0x10, SW[8]=1, press KEY[2] three separate times -> 0x13; no ticks occur and LEDR[8] does not change.
5. KEY[3] and KEY[1] pressed in the same cycle, SW[7:0]=0x33 -> count=0x00 (clear wins). KEY[0] pulsed low mid-count -> LEDR[7:0]=0 without waiting for a clock edge.

Source files
------------

// File: rtl/top.sv
// ============================================================================
// Module   : top
// Brief    : DE-series counter demo with a prescaled 8-bit up/down counter,
//            pushbutton load/step/clear and LED display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module top #(
  parameter int TICK_DIV = 5000000,
  parameter int CNT_W    = 8
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  localparam int              PW          = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   c_last      = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]   c_presc_one = PW'(1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic             w_rst_n;
  logic [2:0]       r_s1;
  logic [2:0]       r_s2;
  logic [2:0]       r_s3;
  logic [2:0]       w_press;
  logic             w_clr;
  logic             w_load;
  logic             w_step;
  logic             w_tick;
  logic [PW-1:0]    r_presc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_adj;
  logic [CNT_W-1:0] w_load_val;
  logic             r_heartbeat;
  logic             w_term;

  assign w_rst_n = KEY[0];

  // Three-stage shift per button; a press is the 1->0 transition between the
  // two oldest stages, so holding or releasing a button yields nothing more.
  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_s1 <= 3'b111;
      r_s2 <= 3'b111;
      r_s3 <= 3'b111;
    end else begin
      r_s1 <= KEY[3:1];
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_press = r_s3 & ~r_s2;
  assign w_load  = w_press[0];
  assign w_step  = w_press[1];
  assign w_clr   = w_press[2];

  assign w_tick      = SW[9] && (r_presc == c_last);
  assign w_count_adj = SW[8] ? (r_count + c_cnt_one) : (r_count - c_cnt_one);
  assign w_load_val  = CNT_W'(SW[7:0]);

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_presc <= '0;
    end else if (w_clr || w_load) begin
      r_presc <= '0;
    end else if (SW[9]) begin
      r_presc <= w_tick ? '0 : (r_presc + c_presc_one);
    end
  end

  // Step and tick in the same cycle still move the count by one only.
  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_count <= '0;
    end else if (w_clr) begin
      r_count <= '0;
    end else if (w_load) begin
      r_count <= w_load_val;
    end else if (w_step || w_tick) begin
      r_count <= w_count_adj;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_heartbeat <= 1'b0;
    end else if (w_tick) begin
      r_heartbeat <= ~r_heartbeat;
    end
  end

  assign w_term = SW[8] ? (r_count == '1) : (r_count == '0);

  assign LEDR[7:0] = 8'(r_count);
  assign LEDR[8]   = r_heartbeat;
  assign LEDR[9]   = w_term;

endmodule

`default_nettype wire

// File: tb/tb_top.sv
// ============================================================================
// Module   : tb_top
// Brief    : Self-checking bench for the counter demo against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top;

  localparam int TD = 4;

  logic       CLOCK_50;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: count, prescaler position, heartbeat, and the KEY[3:1]
  // values seen at the last three rising edges (k1 newest).
  logic [7:0] m_cnt;
  int         m_presc;
  logic       m_hb;
  logic [2:0] m_k1, m_k2, m_k3;

  top #(.TICK_DIV(TD), .CNT_W(8)) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .SW       (SW),
    .LEDR     (LEDR)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [9:0] exp_led();
    logic term;
    term = SW[8] ? (m_cnt == 8'hFF) : (m_cnt == 8'h00);
    return {term, m_hb, m_cnt};
  endfunction

  task automatic model_reset();
    m_cnt = 8'h00; m_presc = 0; m_hb = 1'b0;
    m_k1 = 3'b111; m_k2 = 3'b111; m_k3 = 3'b111;
  endtask

  task automatic set_key(input logic [3:0] v);
    KEY = v;
    if (!v[0]) model_reset();
  endtask

  // Advance one rising edge; the model applies the update rules using the
  // inputs present just before the edge.
  task automatic cycle();
    logic [2:0] press;
    logic       tick;
    if (KEY[0]) begin
      press = m_k3 & ~m_k2;
      tick  = SW[9] && (m_presc == TD - 1);
      if (press[2]) begin
        m_cnt = 8'h00; m_presc = 0;
      end else if (press[0]) begin
        m_cnt = SW[7:0]; m_presc = 0;
      end else begin
        if (press[1] || tick) m_cnt = SW[8] ? m_cnt + 8'd1 : m_cnt - 8'd1;
        if (SW[9]) m_presc = tick ? 0 : m_presc + 1;
      end
      if (tick) m_hb = ~m_hb;
      m_k3 = m_k2; m_k2 = m_k1; m_k1 = KEY[3:1];
    end else begin
      model_reset();
    end
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    SW = 10'b11_0000_0000;
    set_key(4'b1110);
    #1;
    if (LEDR !== 10'h000) begin
      n_err++; $display("FAIL reset_immediate: LEDR=%h expected %h", LEDR, 10'h000);
    end
    n_cmp++;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (LEDR !== 10'h000) begin
        n_err++; $display("FAIL reset_held: LEDR=%h expected %h", LEDR, 10'h000);
      end
      n_cmp++;
    end
    SW[8] = 1'b0;
    #1;
    if (LEDR !== 10'h200) begin
      n_err++; $display("FAIL reset_term_down: LEDR=%h expected %h", LEDR, 10'h200);
    end
    n_cmp++;
    SW[8] = 1'b1;
  endtask

  task automatic test_count_up();
    logic [7:0] want;
    set_key(4'b1111);
    for (int e = 1; e <= 12; e++) begin
      cycle();
      want = 8'(e / TD);
      if (LEDR[7:0] !== want || LEDR[8] !== want[0] || LEDR !== exp_led()) begin
        n_err++;
        $display("FAIL count_up edge %0d: LEDR=%h expected count %h model %h", e, LEDR, want, exp_led());
      end
      n_cmp++;
    end
  endtask

  task automatic test_wrap();
    int  budget;
    budget = 0;
    while (LEDR[7:0] !== 8'hFF && budget < 1200) begin
      cycle();
      budget++;
      if (LEDR !== exp_led()) begin
        n_err++; $display("FAIL wrap_run: LEDR=%h expected %h", LEDR, exp_led());
      end
      n_cmp++;
    end
    if (LEDR[7:0] !== 8'hFF || LEDR[9] !== 1'b1) begin
      n_err++; $display("FAIL wrap_reach_ff: LEDR=%h expected count ff term 1", LEDR);
    end
    n_cmp++;
    for (int i = 0; i < TD; i++) cycle();
    if (LEDR[7:0] !== 8'h00 || LEDR[9] !== 1'b0 || LEDR !== exp_led()) begin
      n_err++; $display("FAIL wrap_up: LEDR=%h expected count 00 term 0", LEDR);
    end
    n_cmp++;
    SW[8] = 1'b0;
    #1;
    if (LEDR[9] !== 1'b1) begin
      n_err++; $display("FAIL term_down_zero: LEDR9=%b expected 1", LEDR[9]);
    end
    n_cmp++;
    for (int i = 0; i < TD; i++) cycle();
    if (LEDR[7:0] !== 8'hFF || LEDR !== exp_led()) begin
      n_err++; $display("FAIL wrap_down: LEDR=%h expected count ff model %h", LEDR, exp_led());
    end
    n_cmp++;
  endtask

  task automatic test_load();
    logic [7:0] old;
    SW = 10'b00_1010_0101;
    old = m_cnt;
    set_key(4'b1101);
    for (int e = 1; e <= 10; e++) begin
      cycle();
      if (LEDR[7:0] !== ((e < 3) ? old : 8'hA5) || LEDR !== exp_led()) begin
        n_err++;
        $display("FAIL load_held edge %0d: LEDR=%h expected count %h", e, LEDR, (e < 3) ? old : 8'hA5);
      end
      n_cmp++;
    end
    set_key(4'b1111);
    for (int e = 0; e < 5; e++) cycle();
    if (LEDR[7:0] !== 8'hA5) begin
      n_err++; $display("FAIL load_release: LEDR=%h expected count a5", LEDR);
    end
    n_cmp++;
  endtask

  task automatic test_step();
    logic hb0;
    SW = 10'b00_0001_0000;
    set_key(4'b1101); cycle();
    set_key(4'b1111); for (int i = 0; i < 4; i++) cycle();
    SW[8] = 1'b1;
    hb0 = LEDR[8];
    for (int p = 0; p < 3; p++) begin
      set_key(4'b1011); cycle(); cycle();
      set_key(4'b1111); for (int i = 0; i < 4; i++) cycle();
    end
    if (LEDR[7:0] !== 8'h13 || LEDR[8] !== hb0 || LEDR !== exp_led()) begin
      n_err++; $display("FAIL step_three: LEDR=%h expected count 13 hb %b", LEDR, hb0);
    end
    n_cmp++;
  endtask

  task automatic test_clear_priority();
    SW = 10'b01_0011_0011;
    set_key(4'b0101);
    for (int i = 0; i < 5; i++) cycle();
    set_key(4'b1111);
    cycle();
    if (LEDR[7:0] !== 8'h00 || LEDR !== exp_led()) begin
      n_err++; $display("FAIL clear_wins: LEDR=%h expected count 00", LEDR);
    end
    n_cmp++;
    SW[9] = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    #2;
    set_key(4'b1110);
    #1;
    if (LEDR[7:0] !== 8'h00 || LEDR[8] !== 1'b0) begin
      n_err++; $display("FAIL async_reset: LEDR=%h expected count 00 hb 0", LEDR);
    end
    n_cmp++;
    cycle();
    set_key(4'b1111);
    for (int e = 1; e <= TD; e++) begin
      cycle();
      if (LEDR[7:0] !== ((e < TD) ? 8'h00 : 8'h01)) begin
        n_err++; $display("FAIL restart edge %0d: LEDR=%h expected count %h", e, LEDR, (e < TD) ? 8'h00 : 8'h01);
      end
      n_cmp++;
    end
  endtask

  task automatic test_random();
    logic [3:0] k;
    for (int i = 0; i < 400; i++) begin
      SW[7:0] = 8'($urandom);
      if ($urandom_range(0, 15) == 0) SW[8] = ~SW[8];
      if ($urandom_range(0, 31) == 0) SW[9] = ~SW[9];
      k = 4'b1111;
      for (int b = 1; b < 4; b++) if ($urandom_range(0, 7) == 0) k[b] = 1'b0;
      if ($urandom_range(0, 99) == 0) k[0] = 1'b0;
      set_key(k);
      #1;
      if (LEDR !== exp_led()) begin
        n_err++; $display("FAIL random_pre %0d: LEDR=%h expected %h", i, LEDR, exp_led());
      end
      n_cmp++;
      cycle();
      if (LEDR !== exp_led()) begin
        n_err++; $display("FAIL random %0d: LEDR=%h expected %h", i, LEDR, exp_led());
      end
      n_cmp++;
    end
  endtask

  initial begin
    SW = 10'b11_0000_0000;
    KEY = 4'b1111;
    model_reset();
    #2;
    test_reset();
    test_count_up();
    test_wrap();
    test_load();
    test_step();
    test_clear_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
